nibble_serial_adder: RTL

Multi-cycle wide adder that adds two 4*N_NIBBLES-bit operands plus carry-in. It processes one nibble per clock through the team's existing 4-bit ripple adder, full_adder_4. A registered carry links each nibble to the next. Both sides use valid/ready handshakes, so the block sits between an operand producer and a result consumer in the datapath.

---
 rtl/nibble_serial_adder_pkg.sv | 13 +
 rtl/nibble_serial_adder_full_adder_4.sv | 26 ++
 rtl/nibble_serial_adder.sv | 117 +++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
// Holds the slice width and the control state encoding used by the top level.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_full_adder_4.sv
// full_adder_4: 4-bit ripple-carry adder, one full-adder cell per bit.
// Ports:
//   x, y   : 4-bit addends
//   c_in   : carry into bit 0
//   s      : 4-bit sum
//   c_out  : carry out of bit 3
module full_adder_4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [4:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]       = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign c_out = carry[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two W-bit operands plus carry-in, one nibble per
// clock, through a single full_adder_4. W = 4*N_NIBBLES.
// Ports:
//   clock, reset_        : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b, c_in           : operands and carry into nibble 0
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   sum, c_out           : registered (a + b + c_in) mod 2^W and final carry
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int N_NIBBLES = 4
) (
  input  logic                            clock,
  input  logic                            reset_,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NIBBLE_W*N_NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*N_NIBBLES-1:0]   b,
  input  logic                            c_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NIBBLE_W*N_NIBBLES-1:0]   sum,
  output logic                            c_out
);

  localparam int W     = NIBBLE_W * N_NIBBLES;
  localparam int CNT_W = $clog2(N_NIBBLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_NIBBLES - 1);

  state_t              state;
  state_t              next_state;
  logic [W-1:0]        op_a;
  logic [W-1:0]        op_b;
  logic                carry;
  logic [CNT_W-1:0]    count;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_carry;
  logic                last_nibble;

  assign last_nibble = (count == LAST);

  // The low nibble of each operand shift register is always the slice being
  // added; the registered carry chains one slice to the next.
  full_adder_4 u_adder (
    .x     (op_a[NIBBLE_W-1:0]),
    .y     (op_b[NIBBLE_W-1:0]),
    .c_in  (carry),
    .s     (nib_sum),
    .c_out (nib_carry)
  );

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake outputs are decoded from state alone so neither ready nor valid
  // has a combinational path from the inputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (last_nibble) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Each RUN cycle pushes the new sum nibble in at the MSB end, so after
  // N_NIBBLES shifts nibble 0 has reached the LSB position. sum and c_out are
  // only written in RUN, so they hold through DONE and the following IDLE.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= b;
            carry <= c_in;
            count <= '0;
          end
        end
        RUN: begin
          sum   <= {nib_sum, sum[W-1:NIBBLE_W]};
          op_a  <= op_a >> NIBBLE_W;
          op_b  <= op_b >> NIBBLE_W;
          carry <= nib_carry;
          count <= count + 1'b1;
          if (last_nibble) c_out <= nib_carry;
        end
        default: ;
      endcase
    end
  end

endmodule
